adc_sar_controller: RTL

- Successive-approximation register (SAR) controller for the 12-bit capacitive-DAC SAR ADC.
- Sequences sampling, then performs one binary-search decision per clock from the comparator output.
- Drives the 12-bit trial code into the DAC row/column/bincap decoder's data input and returns the final conversion result with a one-cycle valid strobe.
- Sits between the comparator and the DAC decoder; it produces the binary code that the decoder turns into thermometer switch controls.

---
 rtl/adc_sar_controller.sv | 130 +++++++++++++
 1 files changed

// File: rtl/adc_sar_controller.sv
// SAR controller for a 12-bit capacitive-DAC ADC: sample, then 12 binary-search trials.
// Optional macro ADC_SAR_CONTINUOUS_EN makes start level-sensitive with back-to-back conversions.
module adc_sar_controller #(
  parameter int unsigned SAMPLE_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic        comp_in,
  output logic        sample_out,
  output logic [11:0] dac_code_out,
  output logic [11:0] result_out,
  output logic        valid_out,
  output logic        busy_out
);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  localparam logic [3:0] SAMPLE_LOAD = 4'(SAMPLE_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  bit_q;
  logic [11:0] code_q;
  logic [11:0] code_d;
  logic [11:0] result_q;
  logic        valid_q;
  logic        sample_q;
  logic        busy_q;
  logic        start_go;

`ifdef ADC_SAR_CONTINUOUS_EN
  assign start_go = start_in;
`else
  logic start_prev_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      start_prev_q <= 1'b0;
    end else begin
      start_prev_q <= start_in;
    end
  end

  assign start_go = start_in & ~start_prev_q;
`endif

  // Resolve the current trial bit from the comparator and arm the next lower bit.
  always_comb begin
    code_d         = code_q;
    code_d[bit_q]  = comp_in;
    if (bit_q != 4'd0) begin
      code_d[bit_q - 4'd1] = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      bit_q    <= 4'd0;
      code_q   <= 12'h000;
      result_q <= 12'h000;
      valid_q  <= 1'b0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_go) begin
            state_q  <= SAMPLE;
            cnt_q    <= SAMPLE_LOAD;
            sample_q <= 1'b1;
            busy_q   <= 1'b1;
            code_q   <= 12'h000;
          end
        end
        SAMPLE: begin
          if (cnt_q == 4'd0) begin
            state_q  <= CONVERT;
            bit_q    <= 4'd11;
            code_q   <= 12'h800;
            sample_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        CONVERT: begin
          code_q <= code_d;
          if (bit_q == 4'd0) begin
            result_q <= code_d;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            bit_q <= bit_q - 4'd1;
          end
        end
        DONE: begin
          code_q <= 12'h000;
`ifdef ADC_SAR_CONTINUOUS_EN
          if (start_in) begin
            state_q  <= SAMPLE;
            cnt_q    <= SAMPLE_LOAD;
            sample_q <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
`else
          state_q <= IDLE;
          busy_q  <= 1'b0;
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sample_out   = sample_q;
  assign dac_code_out = code_q;
  assign result_out   = result_q;
  assign valid_out    = valid_q;
  assign busy_out     = busy_q;

endmodule
